// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the RV32I instruction fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int FETCH_AWIDTH = 32;
    localparam int FETCH_DWIDTH = 32;

    localparam logic [FETCH_AWIDTH-1:0] ZERO     = '0;
    localparam logic [FETCH_DWIDTH-1:0] INSN_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [FETCH_AWIDTH-1:0] pc;
        logic [FETCH_DWIDTH-1:0] insn;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        FETCH_RUN   = 1'b0,
        FETCH_FLUSH = 1'b1
    } fetch_state_e;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Parameterised synchronous FIFO with registered head and clear.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             clear,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_pop;
    logic             w_push;

    // A pop on an empty FIFO is dropped; a push on a full one only lands if a pop frees a slot.
    assign w_pop  = pop && (r_count != '0);
    assign w_push = push && ((r_count != CW'(DEPTH)) || w_pop);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !clear) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : RV32I instruction fetch with credit-limited requests, in-order
//               buffering and redirect flush. Optional macro: FETCH_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                DWIDTH   = FETCH_DWIDTH,
    parameter int                AWIDTH   = FETCH_AWIDTH,
    parameter logic [AWIDTH-1:0] BASEADDR = 32'h0100_0000,
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid_o,
    input  logic              imem_req_ready_i,
    output logic [AWIDTH-1:0] imem_req_addr_o,
    input  logic              imem_rsp_valid_i,
    input  logic [DWIDTH-1:0] imem_rsp_data_i,
    input  logic              redirect_i,
    input  logic [AWIDTH-1:0] redirect_pc_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [AWIDTH-1:0] pc_o,
    output logic [DWIDTH-1:0] insn_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched_o,
    output logic [31:0]       perf_bubble_o
`endif
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_e      r_state;
    fetch_state_e      w_state_nxt;
    logic [AWIDTH-1:0] r_next_pc;
    logic [AWIDTH-1:0] w_next_pc_nxt;
    logic [CW-1:0]     r_kill;
    logic [CW-1:0]     w_kill_nxt;
    logic [CW-1:0]     w_outstanding;
    logic [CW-1:0]     w_k;
    logic [CW-1:0]     w_out_count;
    logic [CW:0]       w_inflight;
    logic [AWIDTH-1:0] w_track_head;
    logic [AWIDTH-1:0] w_target;
    fetch_entry_t      w_out_head;
    fetch_entry_t      w_out_push_data;
    logic              w_credit;
    logic              w_req_fire;
    logic              w_rsp_fire;
    logic              w_deq;
    logic              w_out_push;

    // The tracking FIFO occupancy is the outstanding-request count.
    fetch_fifo #(
        .WIDTH (AWIDTH),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_track_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_req_fire),
        .push_data (r_next_pc),
        .pop       (w_rsp_fire),
        .clear     (1'b0),
        .count     (w_outstanding),
        .head      (w_track_head)
    );

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_out_push),
        .push_data (w_out_push_data),
        .pop       (w_deq),
        .clear     (redirect_i),
        .count     (w_out_count),
        .head      (w_out_head)
    );

    // Credit counts both in-flight requests and buffered entries so the output FIFO never overflows.
    assign w_inflight = {1'b0, w_outstanding} + {1'b0, w_out_count} - {{CW{1'b0}}, w_deq};
    assign w_credit   = w_inflight < (CW + 1)'(DEPTH);

    assign imem_req_valid_o = !rst && (r_state == FETCH_RUN) && w_credit && !redirect_i;
    assign imem_req_addr_o  = r_next_pc;
    assign w_req_fire       = imem_req_valid_o && imem_req_ready_i;
    assign w_rsp_fire       = imem_rsp_valid_i && (w_outstanding != '0);

    assign valid_o = (r_state == FETCH_RUN) && (w_out_count != '0);
    assign w_deq   = valid_o && ready_i;
    assign pc_o    = valid_o ? w_out_head.pc   : ZERO;
    assign insn_o  = valid_o ? w_out_head.insn : INSN_NOP;

    assign w_out_push           = w_rsp_fire && (r_state == FETCH_RUN) && !redirect_i;
    assign w_out_push_data.pc   = w_track_head;
    assign w_out_push_data.insn = imem_rsp_data_i;

    assign w_target = redirect_pc_i & ~AWIDTH'(3);
    // Requests are masked during a redirect, so only a same-cycle response reduces the kill count.
    assign w_k      = w_outstanding - CW'(w_rsp_fire);

    always_comb begin
        w_state_nxt   = r_state;
        w_kill_nxt    = r_kill;
        w_next_pc_nxt = r_next_pc;
        if (redirect_i) begin
            w_next_pc_nxt = w_target;
        end else if (w_req_fire) begin
            w_next_pc_nxt = r_next_pc + AWIDTH'(4);
        end
        case (r_state)
            FETCH_RUN: begin
                if (redirect_i && (w_k != '0)) begin
                    w_kill_nxt  = w_k;
                    w_state_nxt = FETCH_FLUSH;
                end
            end
            FETCH_FLUSH: begin
                if (w_rsp_fire) begin
                    w_kill_nxt = r_kill - CW'(1);
                end
                if (w_kill_nxt == '0) begin
                    w_state_nxt = FETCH_RUN;
                end
            end
            default: begin
                w_state_nxt = FETCH_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= FETCH_RUN;
            r_next_pc <= BASEADDR;
            r_kill    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_next_pc <= w_next_pc_nxt;
            r_kill    <= w_kill_nxt;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_bubble;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetched <= '0;
            r_perf_bubble  <= '0;
        end else begin
            if (w_deq) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (!valid_o && ready_i) begin
                r_perf_bubble <= r_perf_bubble + 32'd1;
            end
        end
    end

    assign perf_fetched_o = r_perf_fetched;
    assign perf_bubble_o  = r_perf_bubble;
`endif

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Scoreboard bench for fetch_unit with an in-order memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int          DEPTH = 2;
    localparam logic [31:0] BASE  = 32'h0100_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i = 1'b0;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_valid_i = 1'b0;
    logic [31:0] imem_rsp_data_i = '0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] pc_o;
    logic [31:0] insn_o;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubble;
`endif

    fetch_unit #(
        .DWIDTH   (32),
        .AWIDTH   (32),
        .BASEADDR (BASE),
        .DEPTH    (DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .valid_o          (valid_o),
        .ready_i          (ready_i),
        .pc_o             (pc_o),
        .insn_o           (insn_o)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched_o   (perf_fetched),
        .perf_bubble_o    (perf_bubble)
`endif
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
    } mreq_t;

    mreq_t        mem_q[$];
    fetch_entry_t exp_q[$];
    logic [31:0]  exp_req_pc = BASE;
    int           epoch = 0;
    int           n_checks = 0;
    int           n_errors = 0;
    int           delivered = 0;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic int old_pending();
        int n = 0;
        foreach (mem_q[i]) if (mem_q[i].epoch != epoch) n++;
        return n;
    endfunction

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    // One clock cycle: drive at the falling edge, then update the model just before the rising edge.
    task automatic step(input bit r, input bit rdy, input bit mrdy, input bit rsp_en,
                        input bit redir, input logic [31:0] tgt, input bit spur);
        bit    has_rsp;
        mreq_t m;
        @(negedge clk);
        rst              = r;
        ready_i          = rdy;
        imem_req_ready_i = mrdy;
        redirect_i       = redir;
        redirect_pc_i    = tgt;
        has_rsp          = rsp_en && !r && (mem_q.size() != 0);
        imem_rsp_valid_i = has_rsp || spur;
        imem_rsp_data_i  = has_rsp ? memfn(mem_q[0].addr) : 32'hDEAD_BEEF;
        #4;
        if (r) begin
            mem_q.delete();
            exp_q.delete();
            exp_req_pc = BASE;
        end else begin
            if (has_rsp) begin
                m = mem_q.pop_front();
                if (!redir && m.epoch == epoch)
                    exp_q.push_back('{pc: m.addr, insn: memfn(m.addr)});
            end
            if (redir) begin
                chk(!imem_req_valid_o, "req_masked_on_redirect", {31'd0, imem_req_valid_o}, 32'd0);
                epoch++;
                exp_q.delete();
                exp_req_pc = tgt & ~32'h3;
            end else if (imem_req_valid_o) begin
                chk(imem_req_addr_o == exp_req_pc, "req_addr", imem_req_addr_o, exp_req_pc);
                if (mrdy) begin
                    mem_q.push_back('{addr: exp_req_pc, epoch: epoch});
                    exp_req_pc = exp_req_pc + 32'd4;
                end
            end
            chk(mem_q.size() + exp_q.size() <= DEPTH, "credit_limit",
                32'(mem_q.size() + exp_q.size()), 32'(DEPTH));
        end
    endtask

    // Monitor: compares every delivered instruction against the scoreboard queue.
    always begin
        fetch_entry_t e;
        @(negedge clk);
        #3;
        if (!rst) begin
            if (old_pending() > 0) begin
                chk(!valid_o, "flush_valid_low", {31'd0, valid_o}, 32'd0);
                chk(!imem_req_valid_o, "flush_no_req", {31'd0, imem_req_valid_o}, 32'd0);
            end
            if (!valid_o) begin
                chk(pc_o == ZERO && insn_o == INSN_NOP, "idle_outputs", insn_o, INSN_NOP);
            end else if (ready_i && !redirect_i) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_deq", pc_o, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk(pc_o == e.pc, "deq_pc", pc_o, e.pc);
                    chk(insn_o == e.insn, "deq_insn", insn_o, e.insn);
                    delivered++;
                end
            end
        end
    end

    initial begin
        int          waited;
        logic [31:0] tgt;

        // Reset values
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1);
        chk(!imem_req_valid_o, "rst_req_valid", {31'd0, imem_req_valid_o}, 32'd0);
        chk(!valid_o, "rst_valid", {31'd0, valid_o}, 32'd0);
        chk(pc_o == ZERO, "rst_pc", pc_o, ZERO);
        chk(insn_o == INSN_NOP, "rst_insn", insn_o, INSN_NOP);
        chk(imem_req_addr_o == BASE, "rst_addr", imem_req_addr_o, BASE);

        // First request timing and steady streaming
        step(0, 1, 1, 1, 0, 0, 0);
        chk(imem_req_valid_o && imem_req_addr_o == BASE, "first_req", imem_req_addr_o, BASE);
        step(0, 1, 1, 1, 0, 0, 0);
        chk(!valid_o, "valid_latency_c1", {31'd0, valid_o}, 32'd0);
        step(0, 1, 1, 1, 0, 0, 0);
        chk(valid_o && pc_o == BASE, "first_valid_pc", pc_o, BASE);
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 1, 1, 0, 0, 0);
            chk(valid_o, "throughput", {31'd0, valid_o}, 32'd1);
        end

        // Decode stall: requests limited to DEPTH, head held
        for (int i = 0; i < 8; i++) step(0, 0, 1, 1, 0, 0, 0);
        chk(!imem_req_valid_o, "stall_req_drop", {31'd0, imem_req_valid_o}, 32'd0);
        chk(valid_o, "stall_head_held", {31'd0, valid_o}, 32'd1);
        chk(exp_q.size() == DEPTH, "stall_buffer_full", 32'(exp_q.size()), 32'(DEPTH));
        for (int i = 0; i < 6; i++) step(0, 1, 1, 1, 0, 0, 0);

        // Memory back-pressure: address must hold
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 0, 0, 0);

        // Two responses in flight, then redirect to an unaligned target
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0, 0, 0);
        chk(mem_q.size() == 2, "two_inflight", 32'(mem_q.size()), 32'd2);
        step(0, 1, 1, 0, 1, 32'h0100_0203, 0);
        chk(old_pending() == 2, "flush_pending", 32'(old_pending()), 32'd2);
        waited = 0;
        do begin
            step(0, 1, 1, 1, 0, 0, 0);
            waited++;
        end while (!(imem_req_valid_o && mem_q.size() <= 1 && old_pending() == 0) && waited < 12);
        chk(waited < 12, "flush_timeout", 32'(waited), 32'd12);
        chk(mem_q.size() >= 1 && mem_q[mem_q.size()-1].addr == 32'h0100_0200,
            "post_flush_addr", (mem_q.size() >= 1) ? mem_q[mem_q.size()-1].addr : 32'd0, 32'h0100_0200);
        for (int i = 0; i < 6; i++) step(0, 1, 1, 1, 0, 0, 0);

        // Redirect together with a response and a dequeue
        step(0, 1, 1, 1, 1, 32'h0100_0800, 0);
        step(0, 1, 1, 1, 0, 0, 0);
        chk(!valid_o, "redir_fifo_cleared", {31'd0, valid_o}, 32'd0);
        chk(mem_q.size() == 1 && mem_q[0].addr == 32'h0100_0800, "redir_next_req",
            (mem_q.size() != 0) ? mem_q[0].addr : 32'd0, 32'h0100_0800);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 1, 0, 0, 0);

        // Address wrap
        step(0, 1, 1, 1, 1, 32'hFFFF_FFF9, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 1, 1, 0, 0, 0);

        // Streaming with frequent redirects
        for (int i = 0; i < 600; i++) begin
            tgt = BASE | ($urandom() & 32'h00FF_FFFF);
            step(0, 1, 1, 1, $urandom_range(0, 99) < 8, tgt, 0);
        end

        // Fully random handshakes
        for (int i = 0; i < 2500; i++) begin
            tgt = BASE | ($urandom() & 32'h00FF_FFFF);
            step(0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 99) < 3, tgt, 0);
        end

        // Mid-stream reset with spurious responses
        for (int i = 0; i < 4; i++) step(0, 1, 1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0, 1);
        step(1, 1, 1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 1);
        chk(imem_req_valid_o && imem_req_addr_o == BASE, "post_rst_req", imem_req_addr_o, BASE);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 0, 0, 0);
            chk(!valid_o && insn_o == INSN_NOP, "spurious_ignored", insn_o, INSN_NOP);
        end

        // Drain
        waited = 0;
        while ((mem_q.size() != 0 || exp_q.size() != 0) && waited < 50) begin
            step(0, 1, 0, 1, 0, 0, 0);
            waited++;
        end
        step(0, 1, 0, 1, 0, 0, 0);
        chk(mem_q.size() == 0 && exp_q.size() == 0, "drain_empty",
            32'(mem_q.size() + exp_q.size()), 32'd0);
        chk(delivered > 1000, "delivered_count", 32'(delivered), 32'd1000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RV32I core. Drives the PC and issues word requests on the instruction-memory request/response interface. Buffers returned instructions with their PCs and presents them to the decode stage over a valid/ready handshake. Also handles control-flow redirects from execute, including discarding responses that are still in flight.

## Interface
- DWIDTH, 32: instruction width.
- AWIDTH, 32: address/PC width.
- BASEADDR, 32'h0100_0000: PC loaded on reset.
- DEPTH, 2: output buffer entries and the maximum number of outstanding requests. Legal values are 2, 4 and 8.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- imem_req_valid_o  out  1  request valid.
- imem_req_ready_i  in  1  memory accepts the request.
- imem_req_addr_o  out  AWIDTH  word address (bits [1:0] = 0).
- imem_rsp_valid_i  in  1  response valid; responses return in order.
- imem_rsp_data_i  in  DWIDTH  instruction word.
- redirect_i  in  1  redirect the PC and flush the buffer.
- redirect_pc_i  in  AWIDTH  target; bits [1:0] are ignored (forced to 0).
- valid_o  out  1  pc_o/insn_o hold a valid instruction.
- ready_i  in  1  decode accepts the head entry.
- pc_o  out  AWIDTH  PC of the head entry; ZERO when !valid_o.
- insn_o  out  DWIDTH  head instruction; INSN_NOP (32'h0000_0013) when !valid_o.

## Operation
- Internal state:
  - next_pc: address of the next request.
  - outstanding counter (0..DEPTH).
  - kill counter (0..DEPTH).
  - PC-tracking FIFO: PCs of requests in flight.
  - output FIFO: {pc, insn} entries awaiting decode.
  - FSM state.
- Fire definitions:
  - req_fire = imem_req_valid_o & imem_req_ready_i
  - deq = valid_o & ready_i
  - rsp_fire = imem_rsp_valid_i & (outstanding != 0)
  - A response that arrives with outstanding == 0 is ignored.
- Credit: a request may issue only if outstanding + out_count - deq < DEPTH. As a result, the output FIFO never overflows.
- Request:
  - imem_req_valid_o = (state == RUN) & credit & !redirect_i.
  - On req_fire: push next_pc into the PC-tracking FIFO, set next_pc += 4, increment outstanding.
  - imem_req_addr_o must stay stable while valid is high and ready is low.
- Response:
  - State RUN: pop the tracked PC and push {pc, imem_rsp_data_i} into the output FIFO.
  - State FLUSH: pop and discard the entry, and decrement kill.
- FSM states:
  - RUN: normal operation. On redirect_i: next_pc ← redirect_pc_i & ~3, output FIFO cleared. Then compute k = outstanding + req_fire - rsp_fire (req_fire is 0 because valid is masked during redirect). If k > 0, set kill ← k and go to FLUSH; otherwise stay in RUN.
  - FLUSH: no requests are issued and valid_o = 0. Go to RUN on the cycle kill reaches 0.
  - A redirect in FLUSH updates next_pc only. The kill count is unaffected because no new requests were made.
- A redirect has priority over a response and a dequeue in the same cycle. The same-cycle response is discarded and is excluded from k.
- next_pc wraps modulo 2^AWIDTH; no fault is raised.
- rst mid-operation:
  - All counters and FIFOs are cleared, next_pc ← BASEADDR, state ← RUN.
  - Responses arriving after reset with outstanding == 0 are ignored.
  - The memory is expected to be reset together with this block.

## Timing
- Reset values:
  - imem_req_valid_o = 0, valid_o = 0, pc_o = ZERO, insn_o = INSN_NOP.
  - imem_req_addr_o = BASEADDR, outstanding = 0, kill = 0, state RUN.
- The first request is asserted in the first cycle after rst deasserts.
- A response captured at edge t is visible on valid_o in cycle t+1 (registered output FIFO, no bypass).
- With 1-cycle memory latency and ready_i held high, throughput is 1 instruction/cycle in steady state.
- After a redirect at edge t, the first request to the target issues in cycle t+1 if the block stays in RUN. Otherwise it issues in the cycle after kill reaches 0.

## Configuration
- FETCH_PERF_EN defined:
  - Adds outputs perf_fetched_o [31:0], which counts deq events.
  - Adds perf_bubble_o [31:0], which counts cycles with !valid_o & ready_i.
  - Both reset to 0 and wrap at 2^32.
- FETCH_PERF_EN undefined: these ports and counters are absent.

## Structure
- Shared package additions:
  - ZERO and INSN_NOP.
  - typedef fetch_entry_t {logic [AWIDTH-1:0] pc; logic [DWIDTH-1:0] insn;}.
  - enum fetch_state_e {FETCH_RUN, FETCH_FLUSH}.
- Sub-module: fetch_fifo, a parameterised synchronous FIFO.
  - Ports: push, pop, clear, count, head.
  - Instantiated twice: PC tracking (width AWIDTH) and output (fetch_entry_t).

## Test plan
- Reset then 1-cycle memory, ready_i = 1 → requests 0x0100_0000, 0x0100_0004, …; valid_o first high 2 cycles after rst falls, with pc_o = 0x0100_0000; one instruction/cycle thereafter.
- Hold ready_i = 0 → at most DEPTH requests issue; imem_req_valid_o drops and valid_o holds the head. Release → entries are delivered in order with no loss or duplicates.
- Two responses in flight, redirect_i with redirect_pc_i = 0x0100_0203 → FLUSH; two responses discarded; next request addr 0x0100_0200; valid_o = 0 until its data returns.
- Redirect in the same cycle as a response and a deq → response discarded, k excludes it; FIFO cleared.
- imem_req_ready_i low for 3 cycles → imem_req_addr_o stable; outstanding unchanged.
- Spurious imem_rsp_valid_i after mid-stream rst → ignored; valid_o = 0, insn_o = 32'h0000_0013.
